// File: rtl/exe_stage.sv
// Execute stage: operand forwarding from MEM/WB, ALU, load-use bubble insertion, EXE/MEM register.
// Optional feature macro: EXE_FORWARDING_EN (forwarding muxes; otherwise any RAW match stalls).
module exe_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [3:0]    exe_cmd_in,
    input  logic          mem_r_en_in,
    input  logic          mem_w_en_in,
    input  logic          wb_en_in,
    input  logic          imm_sel_in,
    input  logic [RW-1:0] dest_in,
    input  logic [RW-1:0] src1_in,
    input  logic [RW-1:0] src2_in,
    input  logic [DW-1:0] val1_in,
    input  logic [DW-1:0] val2_in,
    input  logic [DW-1:0] st_value_in,
    input  logic [DW-1:0] pc_in,
    input  logic          wb_wb_en,
    input  logic [RW-1:0] wb_dest,
    input  logic [DW-1:0] wb_value,
    input  logic          hold_in,
    input  logic          flush_in,
    output logic          stall_req,
    output logic [DW-1:0] alu_result,
    output logic [DW-1:0] st_value,
    output logic [RW-1:0] dest,
    output logic [DW-1:0] pc_out,
    output logic          mem_r_en,
    output logic          mem_w_en,
    output logic          wb_en
);
    localparam logic [3:0] NOP = 4'd10;

    typedef struct packed {
        logic          mem_r_en;
        logic          mem_w_en;
        logic          wb_en;
        logic [RW-1:0] dest;
        logic [DW-1:0] alu;
        logic [DW-1:0] st;
        logic [DW-1:0] pc;
    } exmem_t;

    exmem_t q, cap;

    // src2 only counts as a read when it is a register operand or store data
    logic use2;
    assign use2 = !imm_sel_in || mem_w_en_in;

    function automatic logic raw(input logic [RW-1:0] d, input logic [RW-1:0] s1,
                                 input logic [RW-1:0] s2, input logic u2);
        return (d != '0) && ((d == s1) || ((d == s2) && u2));
    endfunction

    logic ld_hit, hazard;
    logic [DW-1:0] op1, op2, st_data;

    assign ld_hit = q.mem_r_en && raw(q.dest, src1_in, src2_in, use2);

`ifdef EXE_FORWARDING_EN
    // MEM wins over WB; a load's MEM value is not ready, so it never forwards
    function automatic logic [DW-1:0] fwd(input logic [RW-1:0] src, input logic [DW-1:0] rf,
                                          input exmem_t m, input logic we,
                                          input logic [RW-1:0] wd, input logic [DW-1:0] wv);
        if (src == '0)                                   return rf;
        else if (m.wb_en && !m.mem_r_en && m.dest == src) return m.alu;
        else if (we && wd == src)                        return wv;
        else                                             return rf;
    endfunction

    assign op1     = fwd(src1_in, val1_in, q, wb_wb_en, wb_dest, wb_value);
    assign op2     = imm_sel_in ? val2_in : fwd(src2_in, val2_in, q, wb_wb_en, wb_dest, wb_value);
    assign st_data = fwd(src2_in, st_value_in, q, wb_wb_en, wb_dest, wb_value);
    assign hazard  = ld_hit && (exe_cmd_in != NOP) && !flush_in;
`else
    logic ex_hit, wb_hit, unused_wb;
    assign op1       = val1_in;
    assign op2       = val2_in;
    assign st_data   = st_value_in;
    assign unused_wb = ^wb_value;
    assign ex_hit    = q.wb_en && raw(q.dest, src1_in, src2_in, use2);
    assign wb_hit    = wb_wb_en && raw(wb_dest, src1_in, src2_in, use2);
    assign hazard    = (ld_hit || ex_hit || wb_hit) && (exe_cmd_in != NOP) && !flush_in;
`endif

    assign stall_req = hazard && !hold_in;

    logic [DW-1:0] alu;
    logic          op_ok;
    logic [4:0]    sh;
    assign sh = op2[4:0];

    always_comb begin
        alu   = '0;
        op_ok = 1'b1;
        case (exe_cmd_in)
            4'd0:       alu = op1 + op2;
            4'd1:       alu = op1 - op2;
            4'd2:       alu = op1 & op2;
            4'd3:       alu = op1 | op2;
            4'd4:       alu = ~(op1 | op2);
            4'd5:       alu = op1 ^ op2;
            4'd6, 4'd7: alu = op1 << sh;
            4'd8:       alu = DW'($signed(op1) >>> sh);
            4'd9:       alu = op1 >> sh;
            default:    op_ok = 1'b0;
        endcase
    end

    always_comb begin
        cap          = '0;
        cap.mem_r_en = mem_r_en_in && op_ok;
        cap.mem_w_en = mem_w_en_in && op_ok;
        cap.wb_en    = wb_en_in && op_ok;
        cap.dest     = dest_in;
        cap.alu      = alu;
        cap.st       = st_data;
        cap.pc       = pc_in;
    end

    // flush > hold > hazard bubble > capture; an all-zero word is a bubble
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         q <= '0;
        else if (flush_in) q <= '0;
        else if (!hold_in) q <= hazard ? '0 : cap;
    end

    assign alu_result = q.alu;
    assign st_value   = q.st;
    assign dest       = q.dest;
    assign pc_out     = q.pc;
    assign mem_r_en   = q.mem_r_en;
    assign mem_w_en   = q.mem_w_en;
    assign wb_en      = q.wb_en;
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed vectors push expectations, a monitor compares each cycle.
module tb_exe_stage;
    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  exe_cmd_in;
    logic        mem_r_en_in, mem_w_en_in, wb_en_in, imm_sel_in;
    logic [4:0]  dest_in, src1_in, src2_in;
    logic [31:0] val1_in, val2_in, st_value_in, pc_in;
    logic        wb_wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic        hold_in, flush_in;
    logic        stall_req;
    logic [31:0] alu_result, st_value, pc_out;
    logic [4:0]  dest;
    logic        mem_r_en, mem_w_en, wb_en;

    exe_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rstn(rstn), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .imm_sel_in(imm_sel_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .val1_in(val1_in),
        .val2_in(val2_in), .st_value_in(st_value_in), .pc_in(pc_in), .wb_wb_en(wb_wb_en),
        .wb_dest(wb_dest), .wb_value(wb_value), .hold_in(hold_in), .flush_in(flush_in),
        .stall_req(stall_req), .alu_result(alu_result), .st_value(st_value), .dest(dest),
        .pc_out(pc_out), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        bit          is_stall;
        bit          exp_stall;
        logic [4:0]  mask;     // {ctl, dest, alu, st, pc}
        logic [2:0]  ctl;      // {mem_r, mem_w, wb}
        logic [4:0]  dst;
        logic [31:0] alu, st, pc;
    } item_t;

    item_t q[$];
    int drv_cyc = 0, mon_cyc = 0;
    int n_chk = 0, n_pass = 0;

    task automatic check(input string n, input logic [103:0] act, input logic [103:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    always begin
        @(negedge clk);
        mon_cyc++;
        #1;
        while (q.size() > 0 && q[0].cyc <= mon_cyc) begin
            item_t it;
            logic [103:0] m, a, e;
            it = q.pop_front();
            if (it.cyc < mon_cyc) begin
                check({it.name, " missed"}, 104'd1, 104'd0);
            end else if (it.is_stall) begin
                check({it.name, " stall_req"}, {103'd0, stall_req}, {103'd0, it.exp_stall});
            end else begin
                m = {{3{it.mask[4]}}, {5{it.mask[3]}}, {32{it.mask[2]}}, {32{it.mask[1]}}, {32{it.mask[0]}}};
                a = {mem_r_en, mem_w_en, wb_en, dest, alu_result, st_value, pc_out};
                e = {it.ctl, it.dst, it.alu, it.st, it.pc};
                check(it.name, a & m, e & m);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        drv_cyc++;
    endtask

    task automatic set_in(input logic [3:0] c, input logic r, w, wb, imm,
                          input logic [4:0] d, s1, s2, input logic [31:0] v1, v2, st, pc);
        exe_cmd_in = c; mem_r_en_in = r; mem_w_en_in = w; wb_en_in = wb; imm_sel_in = imm;
        dest_in = d; src1_in = s1; src2_in = s2; val1_in = v1; val2_in = v2;
        st_value_in = st; pc_in = pc;
        hold_in = 1'b0; flush_in = 1'b0; wb_wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] d, input logic [31:0] v);
        wb_wb_en = en; wb_dest = d; wb_value = v;
    endtask

    task automatic exp_stall(input string n, input bit s);
        item_t it;
        it = '{cyc: drv_cyc, name: n, is_stall: 1'b1, exp_stall: s, mask: '0,
               ctl: '0, dst: '0, alu: '0, st: '0, pc: '0};
        q.push_back(it);
    endtask

    task automatic exp_reg(input string n, input logic [4:0] m, input logic [2:0] ctl,
                           input logic [4:0] d, input logic [31:0] alu, st, pc);
        item_t it;
        it = '{cyc: drv_cyc + 1, name: n, is_stall: 1'b0, exp_stall: 1'b0, mask: m,
               ctl: ctl, dst: d, alu: alu, st: st, pc: pc};
        q.push_back(it);
    endtask

    task automatic exp_bubble(input string n);
        exp_reg(n, 5'b11000, 3'b000, 5'd0, '0, '0, '0);
    endtask

    task automatic check_all_zero(input string n);
        check({n, " outputs"}, {mem_r_en, mem_w_en, wb_en, dest, alu_result, st_value, pc_out}, 104'd0);
        check({n, " stall_req"}, {103'd0, stall_req}, 104'd0);
    endtask

    logic [31:0] sw_exp [10] = '{32'hF000_0005, 32'hEFFF_FFFD, 32'h0000_0000, 32'hF000_0005,
                                 32'h0FFF_FFFA, 32'hF000_0005, 32'h0000_0010, 32'h0000_0010,
                                 32'hFF00_0000, 32'h0F00_0000};

    initial begin
        rstn = 1'b0;
        set_in(4'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0);
        #2 check_all_zero("reset");
        step(); step();
        rstn = 1'b1;

        // ALU sweep, codes 0..9
        for (int i = 0; i < 10; i++) begin
            step();
            set_in(4'(i), 0, 0, 1, 1, 5'd1, 5'd0, 5'd0, 32'hF000_0001, 32'd4, 32'h11, 32'h1000 + 32'(4 * i));
            exp_stall($sformatf("sweep%0d", i), 1'b0);
            exp_reg($sformatf("sweep%0d", i), 5'b11111, 3'b001, 5'd1, sw_exp[i], 32'h11, 32'h1000 + 32'(4 * i));
        end
        step();
        set_in(4'd10, 0, 1, 1, 1, 5'd2, 5'd0, 5'd0, 32'h5, 32'h6, 32'h0, 32'h1100);
        exp_stall("nop", 1'b0);
        exp_reg("nop", 5'b10100, 3'b000, 5'd0, 32'd0, '0, '0);
        step();
        set_in(4'd12, 1, 0, 1, 1, 5'd2, 5'd0, 5'd0, 32'h5, 32'h6, 32'h0, 32'h1104);
        exp_reg("code12", 5'b10100, 3'b000, 5'd0, 32'd0, '0, '0);

        // forwarding priority: MEM (7) beats WB (9)
        step();
        set_in(4'd0, 0, 0, 1, 1, 5'd3, 5'd0, 5'd0, 32'd3, 32'd4, 32'd0, 32'h1200);
        exp_stall("producer", 1'b0);
        exp_reg("producer", 5'b11111, 3'b001, 5'd3, 32'd7, 32'd0, 32'h1200);
        step();
        set_in(4'd0, 0, 0, 1, 1, 5'd8, 5'd3, 5'd0, 32'd100, 32'd1, 32'd0, 32'h1204);
        set_wb(1'b1, 5'd3, 32'd9);
`ifdef EXE_FORWARDING_EN
        exp_stall("fwd_prio", 1'b0);
        exp_reg("fwd_prio", 5'b11111, 3'b001, 5'd8, 32'd8, 32'd0, 32'h1204);
`else
        exp_stall("raw_mem", 1'b1);
        exp_bubble("raw_mem");
        step();
        exp_stall("raw_wb", 1'b1);
        exp_bubble("raw_wb");
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        val1_in = 32'd7;
        exp_stall("raw_clear", 1'b0);
        exp_reg("raw_clear", 5'b11111, 3'b001, 5'd8, 32'd8, 32'd0, 32'h1204);
`endif
        step();
        set_in(4'd0, 0, 0, 1, 1, 5'd8, 5'd0, 5'd0, 32'd100, 32'd1, 32'd0, 32'h1208);
        set_wb(1'b1, 5'd3, 32'd9);
        exp_stall("src0", 1'b0);
        exp_reg("src0", 5'b11111, 3'b001, 5'd8, 32'd101, 32'd0, 32'h1208);

        // load-use on src2
        step();
        set_in(4'd0, 1, 0, 1, 1, 5'd5, 5'd0, 5'd0, 32'h100, 32'd0, 32'd0, 32'h1300);
        exp_stall("load", 1'b0);
        exp_reg("load", 5'b11111, 3'b101, 5'd5, 32'h100, 32'd0, 32'h1300);
        step();
        set_in(4'd0, 0, 0, 1, 0, 5'd6, 5'd0, 5'd5, 32'd10, 32'd0, 32'd0, 32'h1304);
        exp_stall("load_use", 1'b1);
        exp_bubble("load_use");
        step();
        set_wb(1'b1, 5'd5, 32'd32);
`ifdef EXE_FORWARDING_EN
        exp_stall("retry", 1'b0);
        exp_reg("retry", 5'b11111, 3'b001, 5'd6, 32'd42, 32'd32, 32'h1304);
`else
        exp_stall("retry_wb_raw", 1'b1);
        exp_bubble("retry_wb_raw");
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        val2_in = 32'd32; st_value_in = 32'd32;
        exp_stall("retry", 1'b0);
        exp_reg("retry", 5'b11111, 3'b001, 5'd6, 32'd42, 32'd32, 32'h1304);
`endif

        // hold keeps contents, flush wins over hold
        step();
        set_in(4'd5, 0, 0, 1, 1, 5'd7, 5'd0, 5'd0, 32'hFF00, 32'h0FF0, 32'h55, 32'h2000);
        exp_stall("xor", 1'b0);
        exp_reg("xor", 5'b11111, 3'b001, 5'd7, 32'hF0F0, 32'h55, 32'h2000);
        for (int k = 0; k < 3; k++) begin
            step();
            set_in(4'd0, 0, 0, 1, 1, 5'd9, 5'd0, 5'd0, 32'(k), 32'd1, 32'd0, 32'h3000);
            hold_in = 1'b1;
            exp_stall($sformatf("hold%0d", k), 1'b0);
            exp_reg($sformatf("hold%0d", k), 5'b11111, 3'b001, 5'd7, 32'hF0F0, 32'h55, 32'h2000);
        end
        step();
        hold_in = 1'b1; flush_in = 1'b1;
        exp_stall("hold_flush", 1'b0);
        exp_bubble("hold_flush");

        // hazard deferred by hold, cancelled by flush
        step();
        set_in(4'd0, 1, 0, 1, 1, 5'd5, 5'd0, 5'd0, 32'h400, 32'd0, 32'd0, 32'h4000);
        exp_reg("load2", 5'b11111, 3'b101, 5'd5, 32'h400, 32'd0, 32'h4000);
        step();
        set_in(4'd0, 0, 0, 1, 1, 5'd10, 5'd5, 5'd0, 32'd1, 32'd1, 32'd0, 32'h4004);
        hold_in = 1'b1;
        exp_stall("haz_hold", 1'b0);
        exp_reg("haz_hold", 5'b11111, 3'b101, 5'd5, 32'h400, 32'd0, 32'h4000);
        step();
        hold_in = 1'b0; flush_in = 1'b1;
        exp_stall("haz_flush", 1'b0);
        exp_bubble("haz_flush");

        // store data forwarded from WB while val2 stays the immediate
        step();
        set_in(4'd0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd4, 32'h200, 32'h10, 32'h1234, 32'h5000);
        set_wb(1'b1, 5'd4, 32'hDEAD_BEEF);
`ifdef EXE_FORWARDING_EN
        exp_stall("store", 1'b0);
        exp_reg("store", 5'b11111, 3'b010, 5'd0, 32'h210, 32'hDEAD_BEEF, 32'h5000);
`else
        exp_stall("store_raw", 1'b1);
        exp_bubble("store_raw");
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        st_value_in = 32'hDEAD_BEEF;
        exp_stall("store", 1'b0);
        exp_reg("store", 5'b11111, 3'b010, 5'd0, 32'h210, 32'hDEAD_BEEF, 32'h5000);
`endif

        // asynchronous reset in the middle of a stall
        step();
        set_in(4'd0, 1, 0, 1, 1, 5'd5, 5'd0, 5'd0, 32'h700, 32'd0, 32'd0, 32'h6000);
        exp_reg("load3", 5'b11111, 3'b101, 5'd5, 32'h700, 32'd0, 32'h6000);
        step();
        set_in(4'd0, 0, 0, 1, 1, 5'd11, 5'd5, 5'd0, 32'd1, 32'd1, 32'd0, 32'h6004);
        exp_stall("pre_reset", 1'b1);
        #2 rstn = 1'b0;
        #1 check_all_zero("mid_reset");
        step(); step();
        rstn = 1'b1;
        repeat (3) step();
        if (q.size() != 0) check("queue_drain", 104'(q.size()), 104'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
